mesi_isc_cbus_snoop: RTL

MESI_ISC_CBUS_SNOOP -- requirements
Module: mesi_isc_cbus_snoop

---
 rtl/mesi_isc_pkg.sv | 25 ++
 rtl/mesi_isc_line_table.sv | 39 +++
 rtl/mesi_isc_cbus_snoop.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/mesi_isc_pkg.sv
// Shared definitions for the coherence-bus snoop agent.
//   - coherence-bus command codes (3-bit; codes 5-7 decode as NOP)
//   - MESI line-state encodings (2-bit)
//   - snoop FSM state type
package mesi_isc_pkg;

  localparam logic [2:0] CMD_NOP      = 3'd0;
  localparam logic [2:0] CMD_WR_SNOOP = 3'd1;
  localparam logic [2:0] CMD_RD_SNOOP = 3'd2;
  localparam logic [2:0] CMD_EN_WR    = 3'd3;
  localparam logic [2:0] CMD_EN_RD    = 3'd4;

  localparam logic [1:0] MESI_I = 2'd0;
  localparam logic [1:0] MESI_S = 2'd1;
  localparam logic [1:0] MESI_E = 2'd2;
  localparam logic [1:0] MESI_M = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_WB     = 2'd2,
    ST_ACK    = 2'd3
  } snoop_st_e;

endpackage

// File: rtl/mesi_isc_line_table.sv
// Direct-mapped tag/state array for the snoop agent.
//   clk, rst_n             : clock, async active-low reset (clears to tag 0 / I)
//   i_rd_idx               : combinational read index
//   o_rd_tag, o_rd_state   : read data
//   i_wr_en, i_wr_idx,
//   i_wr_tag, i_wr_state   : single synchronous write port
module mesi_isc_line_table #(
  parameter int LINES_LOG2 = 2,
  parameter int TAG_W      = 28
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [LINES_LOG2-1:0] i_rd_idx,
  output logic [TAG_W-1:0]      o_rd_tag,
  output logic [1:0]            o_rd_state,
  input  logic                  i_wr_en,
  input  logic [LINES_LOG2-1:0] i_wr_idx,
  input  logic [TAG_W-1:0]      i_wr_tag,
  input  logic [1:0]            i_wr_state
);
  localparam int LINES = 1 << LINES_LOG2;

  logic [LINES-1:0][TAG_W-1:0] r_tag;
  logic [LINES-1:0][1:0]       r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag   <= '0;
      r_state <= '0;
    end else if (i_wr_en) begin
      r_tag[i_wr_idx]   <= i_wr_tag;
      r_state[i_wr_idx] <= i_wr_state;
    end
  end

  assign o_rd_tag   = r_tag[i_rd_idx];
  assign o_rd_state = r_state[i_rd_idx];

endmodule

// File: rtl/mesi_isc_cbus_snoop.sv
// Per-CPU coherence-bus snoop agent. Accepts one command at a time from the
// broadcast unit, looks it up in the local line table, requests a writeback
// for dirty hits, updates line state, and closes a four-phase ack handshake.
//   clk, rst                   : clock, async active-low reset
//   cbus_cmd_i, cbus_addr_i    : command slice + address from broadcast unit
//   cbus_ack_o                 : ack, held until command returns to NOP
//   fill_valid_i/addr/state    : local line install, accepted when fill_ready_o
//   wb_req_o, wb_addr_o        : writeback request, held until wb_done_i
//   en_rd_o, en_wr_o           : one-cycle grant pulses to the local CPU
module mesi_isc_cbus_snoop
  import mesi_isc_pkg::*;
#(
  parameter int CBUS_CMD_WIDTH = 3,
  parameter int ADDR_WIDTH     = 32,
  parameter int LINES_LOG2     = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CBUS_CMD_WIDTH-1:0] cbus_cmd_i,
  input  logic [ADDR_WIDTH-1:0]     cbus_addr_i,
  output logic                      cbus_ack_o,
  input  logic                      fill_valid_i,
  input  logic [ADDR_WIDTH-1:0]     fill_addr_i,
  input  logic [1:0]                fill_state_i,
  output logic                      fill_ready_o,
  output logic                      wb_req_o,
  output logic [ADDR_WIDTH-1:0]     wb_addr_o,
  input  logic                      wb_done_i,
  output logic                      en_rd_o,
  output logic                      en_wr_o
);
  localparam int TAG_W = ADDR_WIDTH - LINES_LOG2 - 2;

  // Assert asynchronously, release two clocks later, synchronised to clk.
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_rst_sync <= '0;
    else      r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  snoop_st_e                 r_state, w_state_nxt;
  logic [2:0]                r_cmd;
  logic [ADDR_WIDTH-1:0]     r_addr;
  logic [2:0]                w_cmd;
  logic                      w_cmd_valid;
  logic [TAG_W-1:0]          w_rd_tag;
  logic [1:0]                w_rd_state;
  logic                      w_hit;
  logic                      w_we;
  logic [LINES_LOG2-1:0]     w_wr_idx;
  logic [TAG_W-1:0]          w_wr_tag;
  logic [1:0]                w_wr_state;
  logic                      w_unused_fill_lsb;

  assign w_unused_fill_lsb = ^fill_addr_i[1:0];

  // Only codes 1-4 are real commands; anything else (including codes that
  // would appear with a wider command field) reads as NOP.
  always_comb begin
    w_cmd = CMD_NOP;
    for (int c = 1; c <= 4; c++)
      if (cbus_cmd_i == CBUS_CMD_WIDTH'(c)) w_cmd = 3'(c);
  end
  assign w_cmd_valid = (w_cmd != CMD_NOP);

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= ST_IDLE;
      r_cmd   <= CMD_NOP;
      r_addr  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_IDLE && w_cmd_valid) begin
        r_cmd  <= w_cmd;
        r_addr <= cbus_addr_i;
      end
    end
  end

  mesi_isc_line_table #(.LINES_LOG2(LINES_LOG2), .TAG_W(TAG_W)) u_tbl (
    .clk        (clk),
    .rst_n      (w_rst_n),
    .i_rd_idx   (r_addr[LINES_LOG2+1:2]),
    .o_rd_tag   (w_rd_tag),
    .o_rd_state (w_rd_state),
    .i_wr_en    (w_we),
    .i_wr_idx   (w_wr_idx),
    .i_wr_tag   (w_wr_tag),
    .i_wr_state (w_wr_state)
  );

  assign w_hit = (w_rd_state != MESI_I) && (w_rd_tag == r_addr[ADDR_WIDTH-1:LINES_LOG2+2]);

  // Fills only slip in when no command is pending, so a command arriving in
  // the same cycle always wins.
  assign fill_ready_o = w_rst_n && (r_state == ST_IDLE) && !w_cmd_valid;

  always_comb begin
    w_state_nxt = r_state;
    w_we        = 1'b0;
    w_wr_idx    = r_addr[LINES_LOG2+1:2];
    w_wr_tag    = r_addr[ADDR_WIDTH-1:LINES_LOG2+2];
    w_wr_state  = MESI_I;
    en_rd_o     = 1'b0;
    en_wr_o     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_cmd_valid) begin
          w_state_nxt = ST_LOOKUP;
        end else if (fill_valid_i && fill_ready_o) begin
          w_we       = 1'b1;
          w_wr_idx   = fill_addr_i[LINES_LOG2+1:2];
          w_wr_tag   = fill_addr_i[ADDR_WIDTH-1:LINES_LOG2+2];
          w_wr_state = fill_state_i;
        end
      end
      ST_LOOKUP: begin
        w_state_nxt = ST_ACK;
        case (r_cmd)
          CMD_WR_SNOOP: begin
            if (w_hit && w_rd_state == MESI_M) w_state_nxt = ST_WB;
            else if (w_hit) begin
              w_we       = 1'b1;
              w_wr_state = MESI_I;
            end
          end
          CMD_RD_SNOOP: begin
            if (w_hit && w_rd_state == MESI_M) w_state_nxt = ST_WB;
            else if (w_hit && w_rd_state == MESI_E) begin
              w_we       = 1'b1;
              w_wr_state = MESI_S;
            end
          end
          CMD_EN_RD: en_rd_o = 1'b1;
          CMD_EN_WR: en_wr_o = 1'b1;
          default: ;
        endcase
      end
      ST_WB: begin
        if (wb_done_i) begin
          w_we        = 1'b1;
          w_wr_state  = (r_cmd == CMD_RD_SNOOP) ? MESI_S : MESI_I;
          w_state_nxt = ST_ACK;
        end
      end
      ST_ACK: begin
        if (!w_cmd_valid) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign cbus_ack_o = (r_state == ST_ACK);
  assign wb_req_o   = (r_state == ST_WB);
  assign wb_addr_o  = wb_req_o ? r_addr : '0;

endmodule
